pcs_link_ctrl: RTL and testbench

Link bring-up controller for the PCS receive synchronization block. It powers the synchronizer up and resets it, then watches code_sync_status and the rx_even bit of SUDI. It declares the link up only after sync has held for a link timer, and switches transmit to DATA at that point. If sync is never acquired, it retries a bounded number of times before declaring failure.

---
 rtl/pcs_ctrl_pkg.sv | 49 ++++
 rtl/pcs_link_ctrl_if.sv | 26 ++
 rtl/pcs_cycle_timer.sv | 27 ++
 rtl/pcs_link_ctrl.sv | 151 +++++++++++++++
 tb/tb_pcs_link_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pcs_ctrl_pkg.sv
// Shared types and constants for the PCS link bring-up controller.
package pcs_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_RST     = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_CONFIRM = 3'd3,
    ST_LINK_UP = 3'd4,
    ST_FAIL    = 3'd5
  } link_state_e;

  localparam int DEF_RST_CYCLES        = 2;
  localparam int DEF_ACQ_TIMEOUT       = 64;
  localparam int DEF_LINK_TIMER_CYCLES = 16;
  localparam int DEF_MAX_RETRIES       = 3;
  localparam int DEF_CNT_W             = 8;
  localparam int DEBOUNCE_LEN          = 3;

  typedef struct packed {
    logic power_on;
    logic sync_reset;
    logic xmit_data;
    logic link_ok;
    logic link_fail;
  } link_out_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Moore decode of every controller output from a state value.
  function automatic link_out_t decode_outputs(input link_state_e s);
    link_out_t o;
    o = '0;
    case (s)
      ST_RST:     begin o.power_on = 1'b1; o.sync_reset = 1'b1; end
      ST_ACQUIRE: o.power_on = 1'b1;
      ST_CONFIRM: o.power_on = 1'b1;
      ST_LINK_UP: begin o.power_on = 1'b1; o.xmit_data = 1'b1; o.link_ok = 1'b1; end
      ST_FAIL:    o.link_fail = 1'b1;
      default:    o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pcs_link_ctrl_if.sv
// Signal bundle between the link controller and its management/synchronizer side.
interface pcs_link_ctrl_if #(
  parameter int CNT_W = 8
);
  // All signals are levels sampled on the rising clock edge; there is no valid/ready handshake.
  logic             enable;
  logic             code_sync_status;
  logic             rx_even;
  logic             power_on;
  logic             sync_reset;
  logic             xmit_data;
  logic             link_ok;
  logic             link_fail;
  logic [CNT_W-1:0] loss_count;
  logic [2:0]       state;

  modport master (
    output enable, code_sync_status, rx_even,
    input  power_on, sync_reset, xmit_data, link_ok, link_fail, loss_count, state
  );

  modport slave (
    input  enable, code_sync_status, rx_even,
    output power_on, sync_reset, xmit_data, link_ok, link_fail, loss_count, state
  );
endinterface

// File: rtl/pcs_cycle_timer.sv
// Saturating cycle timer with synchronous clear and a runtime terminal-count limit.
module pcs_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  assign done = (count >= limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pcs_link_ctrl.sv
// PCS receive-sync link bring-up controller. Optional macro LOSS_DEBOUNCE_EN
// requires DEBOUNCE_LEN consecutive sync-low cycles before leaving LINK_UP.
module pcs_link_ctrl
  import pcs_ctrl_pkg::*;
#(
  parameter int RST_CYCLES        = DEF_RST_CYCLES,
  parameter int ACQ_TIMEOUT       = DEF_ACQ_TIMEOUT,
  parameter int LINK_TIMER_CYCLES = DEF_LINK_TIMER_CYCLES,
  parameter int MAX_RETRIES       = DEF_MAX_RETRIES,
  parameter int CNT_W             = DEF_CNT_W
) (
  input logic            Clk,
  input logic            mr_main_reset,
  pcs_link_ctrl_if.slave bus
);

  localparam int TMR_W = $clog2(max3(ACQ_TIMEOUT, LINK_TIMER_CYCLES, RST_CYCLES) + 1);
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);
  localparam logic [TMR_W-1:0] RST_LIM  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] ACQ_LIM  = TMR_W'(ACQ_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LINK_LIM = TMR_W'(LINK_TIMER_CYCLES);

  link_state_e      state_q, state_n;
  link_out_t        out_q;
  logic [RTY_W-1:0] retry_q;
  logic [CNT_W-1:0] loss_q;
  logic             tmr_clear, tmr_en, tmr_done;
  logic [TMR_W-1:0] tmr_limit;
  logic             retry_inc, retry_clr, loss_inc;

`ifdef LOSS_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEBOUNCE_LEN);
  logic [DEB_W-1:0] deb_q;
  logic             deb_inc;
`endif

  // Limit follows the registered state only, so the timer never sees a changing limit mid-count.
  assign tmr_limit = (state_q == ST_RST)     ? RST_LIM :
                     (state_q == ST_ACQUIRE) ? ACQ_LIM : LINK_LIM;

  pcs_cycle_timer #(.W(TMR_W)) u_timer (
    .clk   (Clk),
    .rst_n (mr_main_reset),
    .clear (tmr_clear),
    .en    (tmr_en),
    .limit (tmr_limit),
    .done  (tmr_done)
  );

  always_comb begin
    state_n   = state_q;
    tmr_clear = 1'b1;
    tmr_en    = 1'b0;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    loss_inc  = 1'b0;
`ifdef LOSS_DEBOUNCE_EN
    deb_inc   = 1'b0;
`endif
    if (!bus.enable) begin
      state_n   = ST_OFF;
      retry_clr = 1'b1;
    end else begin
      case (state_q)
        ST_OFF: state_n = ST_RST;
        ST_RST: begin
          if (tmr_done) state_n = ST_ACQUIRE;
          else begin
            tmr_clear = 1'b0;
            tmr_en    = 1'b1;
          end
        end
        ST_ACQUIRE: begin
          if (bus.code_sync_status) begin
            state_n = ST_CONFIRM;
          end else if (tmr_done) begin
            retry_inc = 1'b1;
            state_n   = (retry_q == RTY_W'(MAX_RETRIES - 1)) ? ST_FAIL : ST_RST;
          end else begin
            tmr_clear = 1'b0;
            tmr_en    = 1'b1;
          end
        end
        ST_CONFIRM: begin
          if (!bus.code_sync_status) begin
            state_n = ST_ACQUIRE;
          end else if (tmr_done && bus.rx_even) begin
            state_n   = ST_LINK_UP;
            retry_clr = 1'b1;
          end else begin
            // Holding at the limit while waiting for an even code-group.
            tmr_clear = 1'b0;
            tmr_en    = 1'b1;
          end
        end
        ST_LINK_UP: begin
`ifdef LOSS_DEBOUNCE_EN
          if (!bus.code_sync_status) begin
            if (deb_q == DEB_W'(DEBOUNCE_LEN - 1)) begin
              state_n  = ST_ACQUIRE;
              loss_inc = 1'b1;
            end else begin
              deb_inc = 1'b1;
            end
          end
`else
          if (!bus.code_sync_status) begin
            state_n  = ST_ACQUIRE;
            loss_inc = 1'b1;
          end
`endif
        end
        ST_FAIL: state_n = ST_FAIL;
        default: state_n = ST_OFF;
      endcase
    end
  end

  // Outputs are registered from the next state so they always equal the decode of state_q.
  always_ff @(posedge Clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q <= ST_OFF;
      out_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_n;
      out_q   <= decode_outputs(state_n);
      if (retry_clr)      retry_q <= '0;
      else if (retry_inc) retry_q <= retry_q + 1'b1;
      if (loss_inc && !(&loss_q)) loss_q <= loss_q + 1'b1;
    end
  end

`ifdef LOSS_DEBOUNCE_EN
  always_ff @(posedge Clk or negedge mr_main_reset) begin
    if (!mr_main_reset) deb_q <= '0;
    else if (deb_inc)   deb_q <= deb_q + 1'b1;
    else                deb_q <= '0;
  end
`endif

  assign bus.power_on   = out_q.power_on;
  assign bus.sync_reset = out_q.sync_reset;
  assign bus.xmit_data  = out_q.xmit_data;
  assign bus.link_ok    = out_q.link_ok;
  assign bus.link_fail  = out_q.link_fail;
  assign bus.loss_count = loss_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// Bench for pcs_link_ctrl: spec-level cycle model feeding an expected queue, plus directed checks.
module tb_pcs_link_ctrl;

  localparam int RST_CYCLES        = 2;
  localparam int ACQ_TIMEOUT       = 64;
  localparam int LINK_TIMER_CYCLES = 16;
  localparam int MAX_RETRIES       = 3;
  localparam int VW                = 18;

  logic Clk;
  logic mr_main_reset;

  pcs_link_ctrl_if #(.CNT_W(8)) ifc ();
  pcs_link_ctrl_if #(.CNT_W(2)) ifc2 ();

  assign ifc2.enable           = ifc.enable;
  assign ifc2.code_sync_status = ifc.code_sync_status;
  assign ifc2.rx_even          = ifc.rx_even;

  pcs_link_ctrl #(.CNT_W(8)) dut (
    .Clk           (Clk),
    .mr_main_reset (mr_main_reset),
    .bus           (ifc.slave)
  );

  pcs_link_ctrl #(.CNT_W(2)) dut_sat (
    .Clk           (Clk),
    .mr_main_reset (mr_main_reset),
    .bus           (ifc2.slave)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // scoreboard state
  logic [VW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int sr_cnt   = 0;
  int lo_cnt   = 0;

  // reference model state
  int m_state = 0;
  int m_timer = 0;
  int m_retry = 0;
  int m_loss  = 0;
  int m_loss2 = 0;
`ifdef LOSS_DEBOUNCE_EN
  int m_deb   = 0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] obs_vec();
    return {ifc.state, ifc.power_on, ifc.sync_reset, ifc.xmit_data, ifc.link_ok,
            ifc.link_fail, ifc.loss_count, ifc2.loss_count};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic po, sr, lk, lf;
    logic [2:0] st;
    logic [7:0] l1;
    logic [1:0] l2;
    po = (m_state >= 1) && (m_state <= 4);
    sr = (m_state == 1);
    lk = (m_state == 4);
    lf = (m_state == 5);
    st = 3'(m_state);
    l1 = 8'(m_loss);
    l2 = 2'(m_loss2);
    return {st, po, sr, lk, lk, lf, l1, l2};
  endfunction

  task automatic model_reset();
    m_state = 0; m_timer = 0; m_retry = 0; m_loss = 0; m_loss2 = 0;
`ifdef LOSS_DEBOUNCE_EN
    m_deb = 0;
`endif
  endtask

  task automatic model_loss_exit();
    m_state = 2;
    m_timer = 0;
    if (m_loss < 255) m_loss++;
    if (m_loss2 < 3) m_loss2++;
  endtask

  task automatic model_step(input logic en, input logic sy, input logic rx);
    if (!en) begin
      m_state = 0; m_timer = 0; m_retry = 0;
`ifdef LOSS_DEBOUNCE_EN
      m_deb = 0;
`endif
      return;
    end
    case (m_state)
      0: begin m_state = 1; m_timer = 0; end
      1: begin
        if (m_timer == RST_CYCLES - 1) begin m_state = 2; m_timer = 0; end
        else m_timer++;
      end
      2: begin
        if (sy) begin
          m_state = 3; m_timer = 0;
        end else if (m_timer == ACQ_TIMEOUT - 1) begin
          m_retry++;
          m_timer = 0;
          m_state = (m_retry == MAX_RETRIES) ? 5 : 1;
        end else m_timer++;
      end
      3: begin
        if (!sy) begin
          m_state = 2; m_timer = 0;
        end else if (m_timer == LINK_TIMER_CYCLES && rx) begin
          m_state = 4; m_retry = 0; m_timer = 0;
        end else if (m_timer < LINK_TIMER_CYCLES) m_timer++;
      end
      4: begin
`ifdef LOSS_DEBOUNCE_EN
        if (sy) m_deb = 0;
        else begin
          m_deb++;
          if (m_deb == 3) begin m_deb = 0; model_loss_exit(); end
        end
`else
        if (!sy) model_loss_exit();
`endif
      end
      default: ;
    endcase
  endtask

  // driver: one clock cycle of stimulus, with its expected result queued and checked after the edge
  task automatic tick(input logic en, input logic sy, input logic rx);
    logic [VW-1:0] e;
    ifc.enable = en;
    ifc.code_sync_status = sy;
    ifc.rx_even = rx;
    model_step(en, sy, rx);
    exp_q.push_back(model_vec());
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    check_eq("cycle", obs_vec(), e);
    if (ifc.sync_reset) sr_cnt++;
    if (ifc.link_ok) lo_cnt++;
  endtask

  initial begin
    mr_main_reset = 1'b1;
    ifc.enable = 1'b0;
    ifc.code_sync_status = 1'b0;
    ifc.rx_even = 1'b0;
    #1 mr_main_reset = 1'b0;
    #2 check_eq("reset_hold", obs_vec(), '0);
    #8 mr_main_reset = 1'b1;
    check_eq("reset_state", obs_vec(), '0);

    // 1: bring-up with sync rising 5 cycles into ACQUIRE, rx_even toggling
    sr_cnt = 0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    check_eq("s1_in_acquire", ifc.state, 3'd2);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'(i % 2));
    check_eq("s1_sync_reset_width", sr_cnt, 2);
    check_eq("s1_link", {ifc.link_ok, ifc.xmit_data, ifc.state}, {2'b11, 3'd4});
    check_eq("s1_loss", ifc.loss_count, 0);

    // 3: loss of sync from LINK_UP
`ifdef LOSS_DEBOUNCE_EN
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    check_eq("s3_debounce_hold", ifc.link_ok, 1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
`else
    tick(1'b1, 1'b0, 1'b1);
`endif
    check_eq("s3_exit", {ifc.link_ok, ifc.state}, {1'b0, 3'd2});
    check_eq("s3_loss", ifc.loss_count, 1);

    // 2: sync drops after 8 CONFIRM cycles
    lo_cnt = 0;
    for (int i = 0; i < 9; i++) tick(1'b1, 1'b1, 1'b1);
    check_eq("s2_confirm", ifc.state, 3'd3);
    tick(1'b1, 1'b0, 1'b1);
    check_eq("s2_back_acquire", ifc.state, 3'd2);
    check_eq("s2_no_link", lo_cnt, 0);
    check_eq("s2_loss", ifc.loss_count, 1);

    // 4: sync never acquired -> retries exhausted
    tick(1'b0, 1'b0, 1'b0);
    sr_cnt = 0;
    for (int i = 0; i < 205; i++) tick(1'b1, 1'b0, 1'b0);
    check_eq("s4_sync_reset_rounds", sr_cnt, 6);
    check_eq("s4_fail_flags", {ifc.link_fail, ifc.power_on, ifc.state}, {2'b10, 3'd5});
    tick(1'b0, 1'b0, 1'b0);
    check_eq("s4_off", {ifc.link_fail, ifc.state}, {1'b0, 3'd0});

    // 5: repeated link-up / loss cycles saturate the narrow counter
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 25; i++) tick(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
    end
    check_eq("s5_loss_wide", ifc.loss_count, 6);
    check_eq("s5_loss_sat", ifc2.loss_count, 3);

    // 6: asynchronous reset mid-LINK_UP, between clock edges
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b1);
    check_eq("s6_link_before", ifc.link_ok, 1);
    #3 mr_main_reset = 1'b0;
    #1 check_eq("s6_async_reset", obs_vec(), '0);
    model_reset();
    #2 mr_main_reset = 1'b1;

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)));
    check_eq("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
